btn_conditioner: RTL and testbench

Input conditioner for the board push-buttons. Synchronises each raw `i_btn` line into the `clock` domain, debounces it with a per-channel stability counter, and emits a clean level plus single-cycle press and release pulses. It sits between the board pins and the LED/mode control logic, so colour select and mode toggle advance exactly once per physical press.

---
 rtl/btn_cond_pkg.sv | 19 +
 rtl/btn_debounce_ch.sv | 183 ++++++++++++++++++
 rtl/btn_conditioner.sv | 44 ++++
 tb/tb_btn_conditioner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types for the push-button conditioner: per-channel FSM states,
// the width of the encoded state and a helper that sizes saturating counters.
package btn_cond_pkg;

    localparam int BTN_ST_W = 2;

    typedef enum logic [BTN_ST_W-1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_HELD      = 2'd2,
        ST_RELEASING = 2'd3
    } btn_state_e;

    // Bits needed to hold every value 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One push-button channel: 2-flop synchroniser, stability counter and
// press/release FSM. Optional auto-repeat while held is compiled in when
// BTN_COND_AUTOREPEAT_EN is defined.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | accepted level 0, synchronised input agrees
// ST_ARMING    | accepted level 0, input reads 1, counting stability
// ST_HELD      | accepted level 1, input agrees (repeat timer runs)
// ST_RELEASING | accepted level 1, input reads 0, counting stability
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef BTN_COND_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    // The counter is accepted one step before it would read DEBOUNCE_CYCLES,
    // so it can never pass that value and never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sync;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

`ifdef BTN_COND_AUTOREPEAT_EN
    localparam int               RPT_W = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                   REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_started_q, rpt_started_d;
`endif

    assign sync = sync_q[1];

    // Bring the raw pin into the clock domain; keeps sampling while disabled.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_btn};
        end
    end

    // State, stability counter and registered outputs.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef BTN_COND_AUTOREPEAT_EN
    // Auto-repeat timer: first pulse after REPEAT_DELAY, then every REPEAT_PERIOD.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            rpt_cnt_q     <= '0;
            rpt_started_q <= 1'b0;
        end else begin
            rpt_cnt_q     <= rpt_cnt_d;
            rpt_started_q <= rpt_started_d;
        end
    end
`endif

    // Next-state logic; a disabled channel freezes and emits no pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BTN_COND_AUTOREPEAT_EN
        rpt_cnt_d     = rpt_cnt_q;
        rpt_started_d = rpt_started_q;
`endif
        if (i_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (sync) begin
                        state_d = ST_ARMING;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_ARMING: begin
                    if (!sync) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!sync) begin
                        state_d = ST_RELEASING;
                        cnt_d   = CNT_W'(1);
                    end
`ifdef BTN_COND_AUTOREPEAT_EN
                    else if (!rpt_started_q) begin
                        if (rpt_cnt_q >= RPT_DELAY_LAST) begin
                            press_d       = 1'b1;
                            rpt_cnt_d     = '0;
                            rpt_started_d = 1'b1;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        end
                    end else begin
                        if (rpt_cnt_q >= RPT_PERIOD_LAST) begin
                            press_d   = 1'b1;
                            rpt_cnt_d = '0;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        end
                    end
`endif
                end
                ST_RELEASING: begin
                    if (sync) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end
`ifdef BTN_COND_AUTOREPEAT_EN
        // Any exit from HELD (including a bounce back into RELEASING) restarts the repeat delay.
        if (state_d != ST_HELD) begin
            rpt_cnt_d     = '0;
            rpt_started_d = 1'b0;
        end
`endif
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Board push-button conditioner: N_BTN independent debounced channels giving
// a clean level plus one-cycle press/release pulses. Define
// BTN_COND_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef BTN_COND_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release
);

    // Channels share nothing but clock, reset and enable.
    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_COND_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clock     (clock),
            .i_reset   (i_reset),
            .i_enable  (i_enable),
            .i_btn     (i_btn[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed and randomized checks of btn_conditioner against a run-length
// reference model (a level flips after DEBOUNCE_CYCLES consecutive enabled
// cycles of disagreeing synchronised input).
module tb_btn_conditioner;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int RD = 40;
    localparam int RP = 10;
`ifdef BTN_COND_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clock    = 1'b0;
    logic         i_reset  = 1'b0;
    logic         i_enable = 1'b1;
    logic [N-1:0] i_btn    = '0;
    logic [N-1:0] o_level;
    logic [N-1:0] o_press;
    logic [N-1:0] o_release;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel;
    int           m_run [N];
    int           m_rep [N];
    bit           m_rep_started [N];

    btn_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D)
`ifdef BTN_COND_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_btn     (i_btn),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
        for (int c = 0; c < N; c++) begin
            m_run[c] = 0; m_rep[c] = 0; m_rep_started[c] = 1'b0;
        end
    endtask

    // One clock edge of the reference: uses the inputs present before the edge.
    task automatic model_step();
        logic [N-1:0] seen;
        bit           returning;
        seen = m_s2;
        m_s2 = m_s1;
        m_s1 = i_btn;
        m_press = '0;
        m_rel   = '0;
        if (i_enable) begin
            for (int c = 0; c < N; c++) begin
                if (seen[c] != m_level[c]) begin
                    m_run[c]++;
                    m_rep[c] = 0;
                    m_rep_started[c] = 1'b0;
                    if (m_run[c] == D) begin
                        m_level[c] = ~m_level[c];
                        if (m_level[c]) m_press[c] = 1'b1;
                        else            m_rel[c]   = 1'b1;
                        m_run[c] = 0;
                    end
                end else begin
                    returning = (m_run[c] != 0);
                    m_run[c] = 0;
                    if (returning) begin
                        m_rep[c] = 0;
                        m_rep_started[c] = 1'b0;
                    end else if (AR && m_level[c]) begin
                        m_rep[c]++;
                        if (m_rep[c] == (m_rep_started[c] ? RP : RD)) begin
                            m_press[c] = 1'b1;
                            m_rep[c] = 0;
                            m_rep_started[c] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        chk("level",   o_level,   m_level);
        chk("press",   o_press,   m_press);
        chk("release", o_release, m_rel);
    endtask

    // Ticks until the chosen pulse appears on channel ch and checks how many edges it took.
    task automatic wait_pulse(input int ch, input bit is_press, input int exp_ticks, input string tag);
        int           n;
        bit           found;
        logic [N-1:0] v;
        n = 0;
        found = 1'b0;
        while (!found && n < 60) begin
            tick();
            n++;
            v = is_press ? o_press : o_release;
            if (v[ch]) found = 1'b1;
        end
        chk(tag, n, exp_ticks);
    endtask

    initial begin
        int pulses;
        int first_off;
        int hold [N];

        // Reset with all buttons pressed.
        i_reset = 1'b0;
        i_btn   = 4'hF;
        model_reset();
        repeat (3) begin
            @(posedge clock);
            #1;
            chk("rst_level",   o_level,   4'h0);
            chk("rst_press",   o_press,   4'h0);
            chk("rst_release", o_release, 4'h0);
        end
        i_reset = 1'b1;
        wait_pulse(0, 1'b1, D + 2, "rst_hold_latency");
        chk("rst_hold_press_vec", o_press, 4'hF);
        chk("rst_hold_level_vec", o_level, 4'hF);
        tick();
        chk("rst_hold_press_width", o_press, 4'h0);
        i_btn = 4'h0;
        repeat (25) tick();

        // Clean press and release on channel 1.
        i_btn = 4'b0010;
        wait_pulse(1, 1'b1, D + 2, "ch1_press_latency");
        tick();
        chk("ch1_press_width", o_press, 4'h0);
        repeat (5) tick();
        i_btn = 4'b0000;
        wait_pulse(1, 1'b0, D + 2, "ch1_release_latency");
        tick();
        chk("ch1_release_width", o_release, 4'h0);
        repeat (5) tick();

        // Disable midway through a release count, then resume.
        i_btn = 4'b0010;
        wait_pulse(1, 1'b1, D + 2, "en_press_latency");
        repeat (3) tick();
        i_btn = 4'b0000;
        repeat (6) tick();
        i_enable = 1'b0;
        pulses = 0;
        repeat (20) begin
            tick();
            if (o_release[1] || o_press[1]) pulses++;
        end
        chk("dis_no_pulse", pulses, 0);
        chk("dis_level_hold", o_level[1], 1'b1);
        i_enable = 1'b1;
        wait_pulse(1, 1'b0, 4, "reen_release_latency");
        repeat (5) tick();

        // Bouncing channel 2: 3-cycle toggles never qualify.
        pulses = 0;
        for (int seg = 0; seg < 20; seg++) begin
            i_btn[2] = (seg % 2 == 0);
            repeat (3) begin
                tick();
                if (o_press[2] || o_release[2] || o_level[2]) pulses++;
            end
        end
        chk("bounce_no_output", pulses, 0);
        i_btn[2] = 1'b1;
        wait_pulse(2, 1'b1, D + 2, "bounce_settle_latency");
        i_btn = 4'b0000;
        repeat (15) tick();

        // Simultaneous presses on channels 0 and 3.
        i_btn = 4'b1001;
        wait_pulse(0, 1'b1, D + 2, "simul_latency");
        chk("simul_press_vec", o_press, 4'b1001);
        i_btn = 4'b0000;
        repeat (15) tick();

        // Long hold on channel 0: repeat pulses only when the feature is built in.
        i_btn = 4'b0001;
        wait_pulse(0, 1'b1, D + 2, "hold_accept_latency");
        pulses = 0;
        first_off = 0;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (o_press[0]) begin
                pulses++;
                if (first_off == 0) first_off = t;
            end
        end
        chk("hold_extra_pulses", pulses, AR ? 7 : 0);
        chk("hold_first_repeat", first_off, AR ? RD : 0);
        i_btn = 4'b0000;
        repeat (15) tick();

        // Random bouncing with occasional disable, checked every cycle by the model.
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    i_btn[c] = ~i_btn[c];
                    hold[c] = (($urandom_range(0, 3) == 0) ? $urandom_range(D, 60)
                                                           : $urandom_range(1, 14));
                end
                hold[c]--;
            end
            i_enable = ($urandom_range(0, 15) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
